// File: rtl/txiod_fwd_clk_gen_if.sv
// txiod_fwd_clk_gen_if: link-controller <-> forwarded-clock sequencer bundle.
// RUN_CNT is carried only when TXCLK_RUN_CNT_EN is defined.
interface txiod_fwd_clk_gen_if #(
    parameter int LANES = 1,
    parameter int RATIO = 4
);
    logic                       clk_en;
    logic                       clk_inv;
    logic [LANES-1:0]           lane_mask;
    logic                       resync;
    logic                       tx_sync_rst;
    logic [LANES*RATIO-1:0]     tx_data;
    logic [LANES*RATIO/2-1:0]   oe_data;
    logic                       ready;
    logic                       running;
`ifdef TXCLK_RUN_CNT_EN
    logic [15:0]                run_cnt;
`endif
    modport master (
        output clk_en, clk_inv, lane_mask, resync,
`ifdef TXCLK_RUN_CNT_EN
        input  run_cnt,
`endif
        input  tx_sync_rst, tx_data, oe_data, ready, running
    );
    modport slave (
        input  clk_en, clk_inv, lane_mask, resync,
`ifdef TXCLK_RUN_CNT_EN
        output run_cnt,
`endif
        output tx_sync_rst, tx_data, oe_data, ready, running
    );
endinterface

// File: rtl/txiod_fwd_clk_gen.sv
// txiod_fwd_clk_gen: SYNC/IDLE/PRE/RUN/DRAIN sequencer driving TX IOD forwarded-clock lanes.
// Optional RUN word counter enabled by defining TXCLK_RUN_CNT_EN.
module txiod_fwd_clk_gen #(
    parameter int LANES           = 1,
    parameter int RATIO           = 4,
    parameter int SYNC_RST_CYCLES = 8,
    parameter int PRE_CYCLES      = 4,
    parameter int POST_CYCLES     = 4
) (
    input  logic                 i_fab_clk,
    input  logic                 i_arst_n,
    txiod_fwd_clk_gen_if.slave   bus
);
    localparam int TW = LANES*RATIO;
    localparam int OW = LANES*RATIO/2;
    localparam logic [RATIO-1:0] TOG = {(RATIO/2){2'b01}};

    typedef enum logic [2:0] {S_SYNC, S_IDLE, S_PRE, S_RUN, S_DRAIN} state_t;

    state_t           r_state, w_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_inv, w_inv_nxt;
    logic [LANES-1:0] r_mask, w_mask_nxt;
    logic             w_last, w_entry;
    logic             r_sync_rst, w_sync_rst;
    logic [TW-1:0]    r_tx, w_tx;
    logic [OW-1:0]    r_oe, w_oe;
    logic             r_ready, w_ready;
    logic             r_running, w_running;

    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state    <= S_SYNC;
            r_cnt      <= 8'(SYNC_RST_CYCLES);
            r_inv      <= 1'b0;
            r_mask     <= '0;
            r_sync_rst <= 1'b1;
            r_tx       <= '0;
            r_oe       <= '0;
            r_ready    <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_cnt      <= w_cnt_nxt;
            r_inv      <= w_inv_nxt;
            r_mask     <= w_mask_nxt;
            r_sync_rst <= w_sync_rst;
            r_tx       <= w_tx;
            r_oe       <= w_oe;
            r_ready    <= w_ready;
            r_running  <= w_running;
        end
    end

    // Segment counters load on entry and leave the state on the edge they read 1.
    always_comb begin
        w_last = r_cnt == 8'd1;
        w_nxt  = r_state;
        case (r_state)
            S_SYNC:  w_nxt = w_last ? S_IDLE : S_SYNC;
            S_IDLE:  w_nxt = bus.clk_en ? S_PRE : S_IDLE;
            S_PRE:   w_nxt = w_last ? (bus.clk_en ? S_RUN : S_DRAIN) : S_PRE;
            S_RUN:   w_nxt = bus.clk_en ? S_RUN : S_DRAIN;
            S_DRAIN: w_nxt = w_last ? (bus.clk_en ? S_PRE : S_IDLE) : S_DRAIN;
            default: w_nxt = S_SYNC;
        endcase
        if (bus.resync)
            w_nxt = S_SYNC;
        w_entry    = bus.resync || (w_nxt != r_state);
        w_cnt_nxt  = w_entry ? (w_nxt == S_SYNC  ? 8'(SYNC_RST_CYCLES) :
                                w_nxt == S_PRE   ? 8'(PRE_CYCLES) :
                                w_nxt == S_DRAIN ? 8'(POST_CYCLES) : 8'd0)
                             : (r_cnt == 8'd0 ? 8'd0 : r_cnt - 8'd1);
        w_inv_nxt  = (w_entry && w_nxt == S_PRE) ? bus.clk_inv   : r_inv;
        w_mask_nxt = (w_entry && w_nxt == S_PRE) ? bus.lane_mask : r_mask;
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        w_sync_rst = w_nxt == S_SYNC;
        w_ready    = w_nxt == S_IDLE;
        w_running  = w_nxt == S_RUN;
        w_oe       = (w_nxt == S_PRE || w_nxt == S_RUN || w_nxt == S_DRAIN) ? '1 : '0;
        w_tx       = '0;
        for (int n = 0; n < LANES; n++)
            w_tx[n*RATIO +: RATIO] = (w_nxt == S_RUN && r_mask[n]) ? (r_inv ? ~TOG : TOG) : '0;
    end

    assign bus.tx_sync_rst = r_sync_rst;
    assign bus.tx_data     = r_tx;
    assign bus.oe_data     = r_oe;
    assign bus.ready       = r_ready;
    assign bus.running     = r_running;

`ifdef TXCLK_RUN_CNT_EN
    logic [15:0] r_run_cnt;

    always_ff @(posedge i_fab_clk or negedge i_arst_n) begin
        if (!i_arst_n)
            r_run_cnt <= '0;
        else if (w_nxt == S_SYNC)
            r_run_cnt <= '0;
        else if (w_nxt == S_RUN && r_run_cnt != 16'hFFFF)
            r_run_cnt <= r_run_cnt + 16'd1;
    end

    assign bus.run_cnt = r_run_cnt;
`endif
endmodule

// File: tb/tb_txiod_fwd_clk_gen.sv
// tb_txiod_fwd_clk_gen: directed + random stimulus against a segment-level reference model.
module tb_txiod_fwd_clk_gen;
    localparam int LANES = 2;
    localparam int RATIO = 8;
    localparam int SYNC_N = 8;
    localparam int PRE_N = 4;
    localparam int POST_N = 4;
    localparam int TW = LANES*RATIO;
    localparam int OW = LANES*RATIO/2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    txiod_fwd_clk_gen_if #(.LANES(LANES), .RATIO(RATIO)) bus ();

    txiod_fwd_clk_gen #(
        .LANES(LANES), .RATIO(RATIO), .SYNC_RST_CYCLES(SYNC_N),
        .PRE_CYCLES(PRE_N), .POST_CYCLES(POST_N)
    ) dut (
        .i_fab_clk(clk),
        .i_arst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // phase: 0 SYNC, 1 IDLE, 2 PRE, 3 RUN, 4 DRAIN; done = words spent in segment so far
    int m_phase, m_done, m_runcnt;
    bit m_inv;
    logic [LANES-1:0] m_mask;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] exp_tx();
        logic [TW-1:0] v = '0;
        for (int n = 0; n < LANES; n++)
            for (int b = 0; b < RATIO; b++)
                v[n*RATIO+b] = (m_phase == 3 && m_mask[n]) ? ((b % 2 == 0) != m_inv) : 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_done = 1; m_runcnt = 0; m_inv = 0; m_mask = '0;
    endtask

    task automatic model_edge(input bit en, input bit inv, input logic [LANES-1:0] mask, input bit rs);
        if (rs) begin
            m_phase = 0; m_done = 1; m_runcnt = 0;
        end else begin
            case (m_phase)
                0: if (m_done == SYNC_N) m_phase = 1; else m_done++;
                1: if (en) begin m_phase = 2; m_done = 1; m_inv = inv; m_mask = mask; end
                2: if (m_done == PRE_N) begin
                       if (en) m_phase = 3; else begin m_phase = 4; m_done = 1; end
                   end else m_done++;
                3: if (!en) begin m_phase = 4; m_done = 1; end
                4: if (m_done == POST_N) begin
                       if (en) begin m_phase = 2; m_done = 1; m_inv = inv; m_mask = mask; end
                       else m_phase = 1;
                   end else m_done++;
                default: m_phase = 0;
            endcase
        end
        if (m_phase == 3 && m_runcnt < 65535) m_runcnt++;
    endtask

    task automatic check_all();
        chk("sync_rst", 32'(bus.tx_sync_rst), 32'(m_phase == 0));
        chk("ready", 32'(bus.ready), 32'(m_phase == 1));
        chk("running", 32'(bus.running), 32'(m_phase == 3));
        chk("tx_data", 32'(bus.tx_data), 32'(exp_tx()));
        chk("oe_data", 32'(bus.oe_data), (m_phase >= 2) ? 32'({OW{1'b1}}) : 32'd0);
`ifdef TXCLK_RUN_CNT_EN
        chk("run_cnt", 32'(bus.run_cnt), 32'(m_runcnt));
`endif
    endtask

    task automatic step(input bit en, input bit inv, input logic [LANES-1:0] mask, input bit rs);
        bus.clk_en = en; bus.clk_inv = inv; bus.lane_mask = mask; bus.resync = rs;
        @(posedge clk);
        #1;
        model_edge(en, inv, mask, rs);
        check_all();
    endtask

    task automatic check_reset_vals();
        chk("rst_sync_rst", 32'(bus.tx_sync_rst), 32'd1);
        chk("rst_tx", 32'(bus.tx_data), 32'd0);
        chk("rst_oe", 32'(bus.oe_data), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_running", 32'(bus.running), 32'd0);
`ifdef TXCLK_RUN_CNT_EN
        chk("rst_run_cnt", 32'(bus.run_cnt), 32'd0);
`endif
    endtask

    initial begin
        bit en;
        bus.clk_en = 0; bus.clk_inv = 0; bus.lane_mask = '0; bus.resync = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 check_reset_vals();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < SYNC_N; i++) step(0, 0, 2'b11, 0);
        chk("ready_after_sync", 32'(bus.ready), 32'd1);
        for (int i = 0; i < PRE_N + 10; i++) step(1, 0, 2'b11, 0);
        chk("run_word", 32'(bus.tx_data), 32'h5555);
        for (int i = 0; i < POST_N; i++) step(0, 0, 2'b11, 0);
        chk("drain_oe", 32'(bus.oe_data), 32'hFF);
        step(0, 0, 2'b11, 0);
        chk("idle_after_drain", 32'(bus.ready), 32'd1);
`ifdef TXCLK_RUN_CNT_EN
        chk("run_cnt_10", 32'(bus.run_cnt), 32'd10);
`endif
        for (int i = 0; i < PRE_N + 3; i++) step(1, 1, 2'b10, 0);
        chk("inv_mask_word", 32'(bus.tx_data), 32'hAA00);
        for (int i = 0; i < 3; i++) step(1, 0, 2'b01, 0);
        chk("inv_hold_word", 32'(bus.tx_data), 32'hAA00);
        step(1, 0, 2'b11, 1);
        chk("resync_sync_rst", 32'(bus.tx_sync_rst), 32'd1);
        chk("resync_tx", 32'(bus.tx_data), 32'd0);
        for (int i = 0; i < SYNC_N; i++) step(0, 0, 2'b11, 0);
        chk("resync_ready", 32'(bus.ready), 32'd1);
        step(1, 0, 2'b11, 0); step(0, 0, 2'b11, 0); step(1, 0, 2'b11, 0);
        step(0, 0, 2'b11, 0); step(1, 0, 2'b11, 0);
        chk("pre_toggle_run", 32'(bus.running), 32'd1);
        for (int i = 0; i < 2; i++) step(1, 0, 2'b11, 0);
        step(0, 0, 2'b11, 0); step(1, 0, 2'b11, 0); step(0, 0, 2'b11, 0); step(1, 0, 2'b11, 0);
        step(1, 0, 2'b11, 0);
        chk("drain_to_pre", 32'(bus.oe_data), 32'hFF);
        en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) en = ~en;
            step(en, 1'($urandom), 2'($urandom), $urandom_range(49) == 0);
        end
        rst_n = 1'b0;
        model_reset();
        #2 check_reset_vals();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
